// File: rtl/hazard_detection_ctrl_pkg.sv
// Purpose: shared constants and types for the ID-stage hazard controller.
//   REG_AW / REG_ZERO : register-file address width and the hard-wired $0
//   hz_state_e        : stall FSM encoding (RUN, LD_WAIT)
//   LD_CNT_W          : width of the load-wait down-counter
package hazard_detection_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  localparam int LD_CNT_W = 4;

  typedef enum logic {
    RUN     = 1'b0,
    LD_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_detection_ctrl_if.sv
// Purpose: bundle of pipeline-register fields seen by the hazard controller
//   and the stall/flush controls it returns.
//   master : pipeline side (drives EX/MEM/ID fields, receives controls)
//   slave  : hazard controller side
// There is no valid/ready handshake here: every field is a level that is
// sampled each cycle, and every control output is valid every cycle.
// dbg_state / dbg_cnt expose the stall FSM for observation.
interface hazard_detection_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  import hazard_detection_ctrl_pkg::*;

  logic              idex_mem_read;
  logic              idex_reg_write;
  logic [REG_AW-1:0] idex_rd;
  logic              exmem_mem_read;
  logic [REG_AW-1:0] exmem_rd;
  logic [REG_AW-1:0] ifid_rs;
  logic [REG_AW-1:0] ifid_rt;
  logic              ifid_use_rs;
  logic              ifid_use_rt;
  logic              ifid_is_branch;
  logic              branch_taken;
  logic              jump;

  logic              pc_enable;
  logic              ifid_enable;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_count;

  hz_state_e         dbg_state;
  logic [LD_CNT_W-1:0] dbg_cnt;

  modport master (
    output idex_mem_read, idex_reg_write, idex_rd, exmem_mem_read, exmem_rd,
           ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt, ifid_is_branch,
           branch_taken, jump,
    input  pc_enable, ifid_enable, ifid_flush, idex_bubble, stall_count,
           dbg_state, dbg_cnt
  );

  modport slave (
    input  idex_mem_read, idex_reg_write, idex_rd, exmem_mem_read, exmem_rd,
           ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt, ifid_is_branch,
           branch_taken, jump,
    output pc_enable, ifid_enable, ifid_flush, idex_bubble, stall_count,
           dbg_state, dbg_cnt
  );

endinterface

// File: rtl/hazard_detection_ctrl_reg_match.sv
// Purpose: decide whether a producer destination register is read by the
//   instruction currently in ID. $0 never matches.
//   i_rd              : producer destination register
//   i_rs / i_rt       : ID source registers
//   i_use_rs/i_use_rt : ID instruction actually reads rs / rt
//   o_match           : 1 when a real dependency exists
module hazard_reg_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rd,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic              i_use_rs,
  input  logic              i_use_rt,
  output logic              o_match
);

  logic w_nonzero;
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_nonzero = |i_rd;
  assign w_rs_hit  = i_use_rs && (i_rd == i_rs);
  assign w_rt_hit  = i_use_rt && (i_rd == i_rt);
  assign o_match   = w_nonzero && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/hazard_detection_ctrl.sv
// Purpose: ID-stage hazard controller for the 5-stage MIPS pipeline.
//   Detects load-use hazards (held for LOAD_LAT cycles) and, when branches
//   resolve in ID, branch-operand hazards against EX and MEM. Produces PC /
//   IF-ID hold, ID-EX bubble, IF-ID flush and a saturating stall counter.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous reset, active low
//   bus   : hazard_detection_ctrl_if.slave (pipeline fields in, controls out)
module hazard_detection_ctrl
  import hazard_detection_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int BRANCH_IN_ID = 1,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  hazard_detection_ctrl_if.slave  bus
);

  localparam logic                BR_EN   = (BRANCH_IN_ID != 0);
  localparam logic [LD_CNT_W-1:0] LD_INIT = LD_CNT_W'(LOAD_LAT - 1);
  localparam logic [LD_CNT_W-1:0] LD_ONE  = LD_CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);

  hz_state_e           r_state;
  logic [LD_CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0]    r_stall_count;

  logic w_m_idex;
  logic w_m_exmem;
  logic w_lu;
  logic w_bex;
  logic w_bmem;
  logic w_stall;

  hazard_reg_match #(.REG_AW(REG_AW)) u_match_idex (
    .i_rd     (bus.idex_rd),
    .i_rs     (bus.ifid_rs),
    .i_rt     (bus.ifid_rt),
    .i_use_rs (bus.ifid_use_rs),
    .i_use_rt (bus.ifid_use_rt),
    .o_match  (w_m_idex)
  );

  hazard_reg_match #(.REG_AW(REG_AW)) u_match_exmem (
    .i_rd     (bus.exmem_rd),
    .i_rs     (bus.ifid_rs),
    .i_rt     (bus.ifid_rt),
    .i_use_rs (bus.ifid_use_rs),
    .i_use_rt (bus.ifid_use_rt),
    .o_match  (w_m_exmem)
  );

  assign w_lu   = bus.idex_mem_read && w_m_idex;
  // A load in EX is already covered by LU; BEX only handles ALU producers
  // whose result is forwardable to the ID comparator one cycle later.
  assign w_bex  = BR_EN && bus.ifid_is_branch && bus.idex_reg_write &&
                  !bus.idex_mem_read && w_m_idex;
  assign w_bmem = BR_EN && bus.ifid_is_branch && bus.exmem_mem_read && w_m_exmem;

  // In LD_WAIT the hazard inputs are ignored: the load is still in flight.
  assign w_stall = (r_state == LD_WAIT) || w_lu || w_bex || w_bmem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= RUN;
      r_cnt         <= '0;
      r_stall_count <= '0;
    end else begin
      case (r_state)
        RUN: begin
          // LOAD_LAT=1 is fully served by the combinational LU stall.
          if (w_lu && (LOAD_LAT > 1)) begin
            r_state <= LD_WAIT;
            r_cnt   <= LD_INIT;
          end
        end
        LD_WAIT: begin
          r_cnt <= r_cnt - LD_ONE;
          if (r_cnt == LD_ONE) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase

      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end
    end
  end

  // While reset is held the pipeline is frozen with a bubble into EX,
  // independent of whatever the upstream fields show.
  assign bus.pc_enable   = reset && !w_stall;
  assign bus.ifid_enable = reset && !w_stall;
  assign bus.ifid_flush  = reset && !w_stall && (bus.branch_taken || bus.jump);
  assign bus.idex_bubble = !reset || w_stall;
  assign bus.stall_count = r_stall_count;

  assign bus.dbg_state   = r_state;
  assign bus.dbg_cnt     = r_cnt;

endmodule
